// File: rtl/hms_bcd_counter.sv
// HH:MM:SS time base: a prescaler produces one tick per second, and the tick
// drives six cascaded BCD digits. Manual minute/hour increments are also supported.
module hms_bcd_counter #(
  parameter int TICK_CNTMAX = 49_999_999
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        run,
  input  logic        clr,
  input  logic        inc_min,
  input  logic        inc_hour,
  output logic [23:0] digits,
  output logic        sec_tick,
  output logic        carry_day
);

  localparam int PW = (TICK_CNTMAX > 0) ? $clog2(TICK_CNTMAX + 1) : 1;
  localparam logic [PW-1:0] CNT_LAST = PW'(TICK_CNTMAX);

  logic [PW-1:0] presc_reg, presc_next;
  logic [3:0]    h10_reg, h1_reg, m10_reg, m1_reg, s10_reg, s1_reg;
  logic [3:0]    h10_next, h1_next, m10_next, m1_next, s10_next, s1_next;
  logic          sec_tick_reg, sec_tick_next;
  logic          carry_day_reg, carry_day_next;

  logic tick, manual, s_wrap, m_wrap, h_wrap;
  logic sec_carry, min_step, hour_step;

  always_comb begin
    presc_next     = presc_reg;
    h10_next       = h10_reg;
    h1_next        = h1_reg;
    m10_next       = m10_reg;
    m1_next        = m1_reg;
    s10_next       = s10_reg;
    s1_next        = s1_reg;
    sec_tick_next  = 1'b0;
    carry_day_next = 1'b0;

    tick   = run && (presc_reg == CNT_LAST);
    manual = inc_min || inc_hour;
    s_wrap = (s10_reg == 4'd5) && (s1_reg == 4'd9);
    m_wrap = (m10_reg == 4'd5) && (m1_reg == 4'd9);
    h_wrap = (h10_reg == 4'd2) && (h1_reg == 4'd3);

    // A seconds carry is dropped whenever a manual increment is applied in
    // the same cycle, so minutes/hours only see the operator's request.
    sec_carry = tick && s_wrap;
    min_step  = inc_min || (sec_carry && !manual);
    hour_step = inc_hour || (sec_carry && !manual && m_wrap);

    if (run) begin
      presc_next = tick ? '0 : presc_reg + 1'b1;
    end

    if (tick) begin
      if (s1_reg == 4'd9) begin
        s1_next  = 4'd0;
        s10_next = s_wrap ? 4'd0 : s10_reg + 4'd1;
      end else begin
        s1_next = s1_reg + 4'd1;
      end
    end

    if (min_step) begin
      if (m1_reg == 4'd9) begin
        m1_next  = 4'd0;
        m10_next = m_wrap ? 4'd0 : m10_reg + 4'd1;
      end else begin
        m1_next = m1_reg + 4'd1;
      end
    end

    if (hour_step) begin
      if (h_wrap) begin
        h10_next = 4'd0;
        h1_next  = 4'd0;
      end else if (h1_reg == 4'd9) begin
        h1_next  = 4'd0;
        h10_next = h10_reg + 4'd1;
      end else begin
        h1_next = h1_reg + 4'd1;
      end
    end

    sec_tick_next  = tick;
    carry_day_next = sec_carry && !manual && m_wrap && h_wrap;

    if (clr) begin
      presc_next     = '0;
      h10_next       = 4'd0;
      h1_next        = 4'd0;
      m10_next       = 4'd0;
      m1_next        = 4'd0;
      s10_next       = 4'd0;
      s1_next        = 4'd0;
      sec_tick_next  = 1'b0;
      carry_day_next = 1'b0;
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg     <= '0;
      h10_reg       <= 4'd0;
      h1_reg        <= 4'd0;
      m10_reg       <= 4'd0;
      m1_reg        <= 4'd0;
      s10_reg       <= 4'd0;
      s1_reg        <= 4'd0;
      sec_tick_reg  <= 1'b0;
      carry_day_reg <= 1'b0;
    end else begin
      presc_reg     <= presc_next;
      h10_reg       <= h10_next;
      h1_reg        <= h1_next;
      m10_reg       <= m10_next;
      m1_reg        <= m1_next;
      s10_reg       <= s10_next;
      s1_reg        <= s1_next;
      sec_tick_reg  <= sec_tick_next;
      carry_day_reg <= carry_day_next;
    end
  end

  assign digits    = {h10_reg, h1_reg, m10_reg, m1_reg, s10_reg, s1_reg};
  assign sec_tick  = sec_tick_reg;
  assign carry_day = carry_day_reg;

endmodule

// File: tb/tb_hms_bcd_counter.sv
// Directed bench for hms_bcd_counter with a two-cycle second (TICK_CNTMAX=1).
module tb_hms_bcd_counter;

  logic        clk_50M = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        clr = 1'b0;
  logic        inc_min = 1'b0;
  logic        inc_hour = 1'b0;
  logic [23:0] digits;
  logic        sec_tick;
  logic        carry_day;

  int checks = 0;
  int errors = 0;

  hms_bcd_counter #(.TICK_CNTMAX(1)) dut (
    .clk_50M  (clk_50M),
    .rst_n    (rst_n),
    .run      (run),
    .clr      (clr),
    .inc_min  (inc_min),
    .inc_hour (inc_hour),
    .digits   (digits),
    .sec_tick (sec_tick),
    .carry_day(carry_day)
  );

  always #5 clk_50M = ~clk_50M;

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse(input logic m, input logic h, input int n);
    for (int i = 0; i < n; i++) begin
      inc_min  = m;
      inc_hour = h;
      step();
      inc_min  = 1'b0;
      inc_hour = 1'b0;
    end
  endtask

  task automatic do_reset();
    run = 1'b0; clr = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
    rst_n = 1'b0;
    steps(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    run = 1'b1;
    steps(7);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (digits !== 24'h000000) begin
      errors++; $display("FAIL reset_async_digits: got %06h expected 000000", digits);
    end
    checks++;
    if (sec_tick !== 1'b0 || carry_day !== 1'b0) begin
      errors++; $display("FAIL reset_async_flags: got tick=%b carry=%b expected 0/0", sec_tick, carry_day);
    end
    $display("test_reset: digits=%06h sec_tick=%b", digits, sec_tick);
    step();
    rst_n = 1'b1;
    run = 1'b0;
  endtask

  task automatic test_count();
    int ticks = 0;
    int carries = 0;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 120; i++) begin
      step();
      if (sec_tick) ticks++;
      if (carry_day) carries++;
    end
    checks++;
    if (ticks !== 60) begin
      errors++; $display("FAIL count_ticks: got %0d expected 60", ticks);
    end
    checks++;
    if (digits !== 24'h000100) begin
      errors++; $display("FAIL count_digits: got %06h expected 000100", digits);
    end
    checks++;
    if (carries !== 0) begin
      errors++; $display("FAIL count_carry: got %0d pulses expected 0", carries);
    end
    $display("test_count: ticks=%0d digits=%06h carries=%0d", ticks, digits, carries);
  endtask

  task automatic test_rollover();
    int ticks = 0;
    int carries = 0;
    int carry_at = -1;
    logic [23:0] at60 = 24'hFFFFFF;
    do_reset();
    pulse(1'b0, 1'b1, 23);
    pulse(1'b1, 1'b0, 59);
    checks++;
    if (digits !== 24'h235900) begin
      errors++; $display("FAIL rollover_preset: got %06h expected 235900", digits);
    end
    run = 1'b1;
    for (int i = 0; i < 120; i++) begin
      step();
      if (sec_tick) begin
        ticks++;
        if (ticks == 60) at60 = digits;
      end
      if (carry_day) begin
        carries++;
        carry_at = sec_tick ? ticks : -2;
      end
    end
    run = 1'b0;
    checks++;
    if (at60 !== 24'h000000) begin
      errors++; $display("FAIL rollover_digits: got %06h expected 000000", at60);
    end
    checks++;
    if (carries !== 1) begin
      errors++; $display("FAIL rollover_carry_count: got %0d expected 1", carries);
    end
    checks++;
    if (carry_at !== 60) begin
      errors++; $display("FAIL rollover_carry_when: got tick %0d expected 60", carry_at);
    end
    $display("test_rollover: digits@60=%06h carries=%0d at tick %0d", at60, carries, carry_at);
  endtask

  task automatic test_collision();
    do_reset();
    pulse(1'b1, 1'b0, 59);
    run = 1'b1;
    steps(118);
    checks++;
    if (digits !== 24'h005959) begin
      errors++; $display("FAIL collision_preset: got %06h expected 005959", digits);
    end
    step();
    inc_min = 1'b1;
    step();
    inc_min = 1'b0;
    run = 1'b0;
    checks++;
    if (digits !== 24'h000000 || sec_tick !== 1'b1) begin
      errors++; $display("FAIL collision_digits: got %06h tick=%b expected 000000 tick=1", digits, sec_tick);
    end
    checks++;
    if (carry_day !== 1'b0) begin
      errors++; $display("FAIL collision_carry: got %b expected 0", carry_day);
    end
    $display("test_collision: digits=%06h sec_tick=%b carry_day=%b", digits, sec_tick, carry_day);
    step();
    pulse(1'b1, 1'b1, 1);
    checks++;
    if (digits !== 24'h010100) begin
      errors++; $display("FAIL both_inc: got %06h expected 010100", digits);
    end
    pulse(1'b0, 1'b1, 22);
    checks++;
    if (digits !== 24'h230100) begin
      errors++; $display("FAIL hour_preset: got %06h expected 230100", digits);
    end
    pulse(1'b0, 1'b1, 1);
    checks++;
    if (digits !== 24'h000100) begin
      errors++; $display("FAIL hour_wrap: got %06h expected 000100", digits);
    end
    $display("test_collision: hour wrap digits=%06h", digits);
  endtask

  task automatic test_hold();
    int bad = 0;
    do_reset();
    run = 1'b1;
    steps(15);
    run = 1'b0;
    checks++;
    if (digits !== 24'h000007) begin
      errors++; $display("FAIL hold_preset: got %06h expected 000007", digits);
    end
    for (int i = 0; i < 50; i++) begin
      step();
      if (digits !== 24'h000007 || sec_tick !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL hold_stable: got %0d bad cycles expected 0", bad);
    end
    run = 1'b1;
    step();
    checks++;
    if (sec_tick !== 1'b1 || digits !== 24'h000008) begin
      errors++; $display("FAIL hold_resume: got tick=%b digits=%06h expected 1/000008", sec_tick, digits);
    end
    run = 1'b0;
    $display("test_hold: bad=%0d resume digits=%06h", bad, digits);
  endtask

  task automatic test_clear();
    do_reset();
    pulse(1'b0, 1'b1, 12);
    pulse(1'b1, 1'b0, 34);
    run = 1'b1;
    steps(112);
    checks++;
    if (digits !== 24'h123456) begin
      errors++; $display("FAIL clear_preset: got %06h expected 123456", digits);
    end
    step();
    clr = 1'b1;
    inc_min = 1'b1;
    step();
    clr = 1'b0;
    inc_min = 1'b0;
    checks++;
    if (digits !== 24'h000000 || sec_tick !== 1'b0 || carry_day !== 1'b0) begin
      errors++; $display("FAIL clear_result: got %06h tick=%b carry=%b expected 000000/0/0", digits, sec_tick, carry_day);
    end
    step();
    checks++;
    if (sec_tick !== 1'b0) begin
      errors++; $display("FAIL clear_presc1: got tick=%b expected 0", sec_tick);
    end
    step();
    checks++;
    if (sec_tick !== 1'b1 || digits !== 24'h000001) begin
      errors++; $display("FAIL clear_presc2: got tick=%b digits=%06h expected 1/000001", sec_tick, digits);
    end
    $display("test_clear: after clear and 2 cycles digits=%06h", digits);
  endtask

  task automatic test_reset_midsecond();
    int wait_cycles = 0;
    bit seen = 0;
    do_reset();
    run = 1'b1;
    steps(5);
    #3;
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
    while (!seen && wait_cycles < 10) begin
      step();
      wait_cycles++;
      if (sec_tick) seen = 1;
    end
    checks++;
    if (!seen || wait_cycles !== 2) begin
      errors++; $display("FAIL reset_midsecond: got first tick after %0d cycles (seen=%0d) expected 2", wait_cycles, seen);
    end
    checks++;
    if (digits !== 24'h000001) begin
      errors++; $display("FAIL reset_midsecond_digits: got %06h expected 000001", digits);
    end
    run = 1'b0;
    $display("test_reset_midsecond: first tick after %0d cycles digits=%06h", wait_cycles, digits);
  endtask

  initial begin
    test_reset();
    test_count();
    test_rollover();
    test_collision();
    test_hold();
    test_clear();
    test_reset_midsecond();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hms_bcd_counter.md
HMS_BCD_COUNTER -- requirements
Module: hms_bcd_counter

Upstream time source for the six-digit dynamic display. Produces HH:MM:SS as six BCD digits.

Interface
REQ-001 Parameter: TICK_CNTMAX, default 49_999_999, last prescaler count; one second = TICK_CNTMAX+1 clocks at 50 MHz.
REQ-002 clk_50M  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 run  input  1  count enable; 0 = prescaler and digits hold.
REQ-005 clr  input  1  synchronous clear of time and prescaler.
REQ-006 inc_min  input  1  single-cycle pulse; advance minutes by one.
REQ-007 inc_hour  input  1  single-cycle pulse; advance hours by one.
REQ-008 digits  output  24  {h10,h1,m10,m1,s10,s1}, 4 bits each, MSB-first; h10 in [23:20].
REQ-009 sec_tick  output  1  one-cycle pulse per elapsed second.
REQ-010 carry_day  output  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover.

Function
REQ-011 Prescaler SHALL count 0..TICK_CNTMAX while run=1, wrap to 0 after TICK_CNTMAX, and hold its value while run=0.
REQ-012 sec_tick SHALL be registered, high for exactly the one cycle after the edge on which prescaler==TICK_CNTMAX with run=1.
REQ-013 Digit update from a tick SHALL occur on the same edge that raises sec_tick (new value visible while sec_tick=1).
REQ-014 Seconds: s1 0..9, carry to s10 0..5; 59 -> 00 with carry to minutes.
REQ-015 Minutes: m1 0..9, carry to m10 0..5; 59 -> 00 with carry to hours.
REQ-016 Hours: 00..23; 23 -> 00 (h1 wraps at 3 when h10=2, else at 9).
REQ-017 carry_day SHALL be high in the same cycle as sec_tick when the tick changes 23:59:59 to 00:00:00, otherwise 0.
REQ-018 inc_min SHALL advance minutes mod 60 with no carry into hours and leave seconds unchanged; inc_hour SHALL advance hours mod 24.
REQ-019 inc_min and inc_hour in the same cycle SHALL both apply independently.
REQ-020 A tick coinciding with inc_min or inc_hour SHALL still advance seconds, but a seconds carry that cycle SHALL be dropped (seconds 59 -> 00, minutes take only the manual increment); carry_day SHALL be 0 that cycle.
REQ-021 inc_min/inc_hour SHALL act regardless of run.
REQ-022 Priority: rst_n > clr > manual increments > tick.
REQ-023 clr=1 SHALL set digits=24'h000000, prescaler=0, sec_tick=0, carry_day=0 on the next edge, ignoring all other inputs that cycle.
REQ-024 Every digit SHALL always hold legal BCD within its field range; no illegal value is reachable from reset.

Reset
REQ-025 rst_n=0 SHALL immediately (without a clock) force digits=24'h000000, prescaler=0, sec_tick=0, carry_day=0.
REQ-026 Reset asserted mid-second SHALL discard the partial prescaler count; after release the first tick SHALL occur TICK_CNTMAX+1 run-cycles later.

Verification (bench uses TICK_CNTMAX=1, i.e. tick every 2 cycles)
REQ-027 Reset: rst_n=0 between edges -> digits=000000, sec_tick=0 without waiting for a clock edge.
REQ-028 Count: run=1 for 120 cycles from reset -> exactly 60 sec_tick pulses, digits=24'h000100, carry_day never 1.
REQ-029 Day rollover: 23 inc_hour, 59 inc_min pulses (run=0), then run=1 for 120 cycles -> digits=24'h000000 after 60th tick, carry_day exactly one pulse coincident with that sec_tick.
REQ-030 Manual wrap/collision: at 00:59:59, inc_min on the same cycle as a tick -> digits=24'h000000, hours unchanged, carry_day=0; at 23:xx, inc_hour -> h=00.
REQ-031 Hold: run=0 at 00:00:07 for 50 cycles -> digits stay 24'h000007, no sec_tick; run=1 -> next tick after remaining prescaler count.
REQ-032 Clear/reset mid-operation: clr pulse at 12:34:56 -> 24'h000000 next edge, clr taking precedence over a concurrent inc_min; rst_n pulse mid-second -> first tick 2 cycles after release.
